piezo_tune_seq: RTL
===================

// Module: piezo_tune_seq
// PURPOSE
//  Tune sequencer that sits directly upstream of the piezo frequency counter.
//  Steps through a fixed note table and drives that counter's note_per and clr inputs.
//  Each note sounds for a programmed number of ticks, followed by a silent inter-note gap.
//  Start/abort handshake and busy/done status go to the host FSM.
// PARAMETERS
//  NUM_NOTES  3      entries in tune table (1..256)
//  TICK_CYC   50000  clk cycles per duration tick (1 ms @ 50 MHz), >=1
//  GAP_TICKS  10     silent ticks after every note; 0 = no gap
// PORTS
//  clk       in   1   system clock (50 MHz); the block's only clock
//  rst       in   1   reset, asynchronous, active-high
//  start     in   1   level sampled on clk; begins tune when idle
//  abort     in   1   stop tune immediately, return idle
//  note_per  out  15  period to counter; held stable for a whole note+gap
//  clr       out  1   silence/clear to counter (1 = counter held at 0)
//  busy      out  1   tune in progress
//  done      out  1   1-cycle pulse on normal completion
//  note_idx  out  8   index of current table entry
// BEHAVIOUR
//  - Reset (async, immediate): state IDLE, note_per=0, clr=1, busy=0, done=0, note_idx=0,
//    prescaler/duration/gap counters=0. Reset asserted mid-tune aborts with no done pulse.
//  - Table entry = {per[14:0], dur[7:0]}; per=0 is a rest (clr stays 1); dur=0 is end marker.
//  - States: IDLE, PLAY, GAP.
//  - IDLE: clr=1, busy=0. start=1 & abort=0 -> next edge: PLAY, note_idx=0, entry 0 loaded.
//    If entry 0 has dur=0 -> stay IDLE, pulse done.
//  - Note load (same edge as state change): note_per<=entry.per; dur_cnt<=entry.dur;
//    prescaler<=0; clr<=(entry.per==0). Latency start->sound = 1 cycle.
//  - Prescaler counts 0..TICK_CYC-1 and wraps; tick = (prescaler==TICK_CYC-1).
//  - PLAY: on tick, dur_cnt--. tick & dur_cnt==1 -> GAP, clr<=1, gap_cnt<=GAP_TICKS.
//    PLAY lasts exactly dur*TICK_CYC cycles.
//  - GAP: clr=1, lasts GAP_TICKS*TICK_CYC cycles (0 cycles if GAP_TICKS=0).
//  - GAP end, i.e. the last note's end when GAP_TICKS=0:
//    if note_idx==NUM_NOTES-1 or next entry dur==0 -> IDLE, done=1 for one cycle, busy<=0.
//    else note_idx++ and load next entry -> PLAY.
//  - note_per keeps its last value in IDLE; only clr guarantees silence.
//  - start while busy: ignored, no restart.
//  - abort=1 in any state: next edge -> IDLE, clr=1, busy=0, no done pulse.
//  - abort and start in the same cycle: abort wins.
//  - busy=1 in PLAY and GAP only. done and busy are never both 1.
//  - All outputs are registered; no combinational path from inputs to outputs.
// STRUCTURE
//  - piezo_pkg: typedef note_t {logic [14:0] per; logic [7:0] dur;},
//    typedef enum {IDLE,PLAY,GAP} seq_state_t, note period constants
//    (G6=31888, C7=23889, E7=18961, REST=0). note_per must be >=16384 to be audible.
//  - Sub-module piezo_tune_rom: combinational case ROM, note_idx -> note_t.
//  - Top level: state register, prescaler, dur/gap counters, output registers.
// TESTING (TICK_CYC=4, GAP_TICKS=2, NUM_NOTES=3;
//          table {G6,dur2},{REST,dur1},{C7,dur3})
//  1 rst pulse mid-PLAY with no clk edge -> clr=1, busy=0, note_per=0, note_idx=0
//    immediately. Next start replays from idx 0.
//  2 start 1 cycle -> next cycle busy=1, clr=0, note_per=31888 for 8 cycles; clr=1 for 8;
//    idx1 rest, clr=1 for 4+8; note_per=23889 with clr=0 for 12; clr=1 for 8;
//    done for 1 cycle, busy=0. Total 48 cycles busy.
//  3 start held high throughout tune -> no restart while busy. Tune restarts the cycle after
//    done if start is still high; idx sequence is 0,1,2 each pass.
//  4 abort at cycle 5 of note 0 -> next cycle IDLE, clr=1, busy=0, done never pulses.
//  5 start & abort same cycle in IDLE -> stays IDLE, busy stays 0.
//  6 table entry 1 dur=0 (end marker) -> after note 0 and its gap (16 cycles) done pulses.
//    note_idx never reaches 1 audibly.

Source files
------------

// File: rtl/piezo_pkg.sv
// rtl/piezo_pkg.sv - shared types and note period constants for the tune sequencer
// Purpose: note table entry type, sequencer state encoding, note period constants.
// A note_per value must be >= 16384 to be audible on the downstream counter.
package piezo_pkg;

    typedef struct packed {
        logic [14:0] per;
        logic [7:0]  dur;
    } note_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } seq_state_t;

    localparam logic [14:0] NOTE_G6   = 15'd31888;
    localparam logic [14:0] NOTE_C7   = 15'd23889;
    localparam logic [14:0] NOTE_E7   = 15'd18961;
    localparam logic [14:0] NOTE_REST = 15'd0;

endpackage

// File: rtl/piezo_tune_rom.sv
// rtl/piezo_tune_rom.sv - combinational tune table, index to note entry
// Purpose: fixed note table. TUNE_SEL=1 selects a variant whose entry 1 is an end marker.
// Ports:
//   idx   in  8   table index
//   entry out 23  {per[14:0], dur[7:0]}; unused indices read as end marker (dur=0)
module piezo_tune_rom
    import piezo_pkg::*;
#(
    parameter int TUNE_SEL = 0
) (
    input  logic [7:0] idx,
    output note_t      entry
);

    always_comb begin
        entry.per = NOTE_REST;
        entry.dur = 8'd0;
        case (idx)
            8'd0: begin
                entry.per = NOTE_G6;
                entry.dur = 8'd2;
            end
            8'd1: begin
                entry.per = NOTE_REST;
                entry.dur = (TUNE_SEL == 1) ? 8'd0 : 8'd1;
            end
            8'd2: begin
                entry.per = NOTE_C7;
                entry.dur = 8'd3;
            end
            default: begin
                entry.per = NOTE_REST;
                entry.dur = 8'd0;
            end
        endcase
    end

endmodule

// File: rtl/piezo_tune_seq.sv
// rtl/piezo_tune_seq.sv - tune sequencer driving the piezo frequency counter
// Purpose: plays the note table entry by entry, each note followed by a silent gap.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start, abort    host handshake (abort has priority)
//   note_per [14:0] period to counter, held for a whole note plus gap
//   clr             1 = counter silenced
//   busy, done      tune in progress / 1-cycle completion pulse
//   note_idx [7:0]  current table index
module piezo_tune_seq
    import piezo_pkg::*;
#(
    parameter int NUM_NOTES = 3,
    parameter int TICK_CYC  = 50000,
    parameter int GAP_TICKS = 10,
    parameter int TUNE_SEL  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic [14:0] note_per,
    output logic        clr,
    output logic        busy,
    output logic        done,
    output logic [7:0]  note_idx
);

    localparam int PW = $clog2(TICK_CYC + 1);
    localparam int GW = $clog2(GAP_TICKS + 2);

    seq_state_t  state_q, state_d;
    logic [14:0] note_per_q, note_per_d;
    logic        clr_q, clr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  note_idx_q, note_idx_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]  dur_cnt_q, dur_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;

    logic [7:0]  rom_addr;
    note_t       rom_entry;
    logic        tick;
    logic        note_end;
    logic        load;
    logic        last_note;

    // In IDLE the ROM shows entry 0; while playing it looks one entry ahead so
    // the next note (or end marker) is ready at the end of the current gap.
    assign rom_addr = (state_q == IDLE) ? 8'd0 : note_idx_q + 8'd1;

    piezo_tune_rom #(.TUNE_SEL(TUNE_SEL)) u_rom (
        .idx   (rom_addr),
        .entry (rom_entry)
    );

    assign tick      = (presc_q == PW'(TICK_CYC - 1));
    assign last_note = (note_idx_q == 8'(NUM_NOTES - 1)) || (rom_entry.dur == 8'd0);

    always_comb begin
        state_d    = state_q;
        note_per_d = note_per_q;
        clr_d      = clr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        note_idx_d = note_idx_q;
        presc_d    = presc_q;
        dur_cnt_d  = dur_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        note_end   = 1'b0;
        load       = 1'b0;

        case (state_q)
            IDLE: begin
                presc_d = '0;
                if (start) begin
                    if (rom_entry.dur == 8'd0) begin
                        done_d = 1'b1;
                    end else begin
                        note_idx_d = 8'd0;
                        load       = 1'b1;
                    end
                end
            end
            PLAY: begin
                presc_d = tick ? '0 : presc_q + PW'(1);
                if (tick) begin
                    dur_cnt_d = dur_cnt_q - 8'd1;
                    if (dur_cnt_q == 8'd1) begin
                        if (GAP_TICKS == 0) begin
                            note_end = 1'b1;
                        end else begin
                            state_d   = GAP;
                            clr_d     = 1'b1;
                            gap_cnt_d = GW'(GAP_TICKS);
                        end
                    end
                end
            end
            GAP: begin
                presc_d = tick ? '0 : presc_q + PW'(1);
                if (tick) begin
                    gap_cnt_d = gap_cnt_q - GW'(1);
                    if (gap_cnt_q == GW'(1)) begin
                        note_end = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (note_end) begin
            if (last_note) begin
                state_d = IDLE;
                clr_d   = 1'b1;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                presc_d = '0;
            end else begin
                note_idx_d = note_idx_q + 8'd1;
                load       = 1'b1;
            end
        end

        // rom_entry is the entry being loaded: entry 0 from IDLE, next entry otherwise.
        if (load) begin
            state_d    = PLAY;
            note_per_d = rom_entry.per;
            dur_cnt_d  = rom_entry.dur;
            presc_d    = '0;
            clr_d      = (rom_entry.per == NOTE_REST);
            busy_d     = 1'b1;
        end

        if (abort) begin
            state_d    = IDLE;
            clr_d      = 1'b1;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            note_idx_d = note_idx_q;
            note_per_d = note_per_q;
            presc_d    = '0;
            dur_cnt_d  = 8'd0;
            gap_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            note_per_q <= 15'd0;
            clr_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            note_idx_q <= 8'd0;
            presc_q    <= '0;
            dur_cnt_q  <= 8'd0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            note_per_q <= note_per_d;
            clr_q      <= clr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            note_idx_q <= note_idx_d;
            presc_q    <= presc_d;
            dur_cnt_q  <= dur_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    assign note_per = note_per_q;
    assign clr      = clr_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign note_idx = note_idx_q;

endmodule
